fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 135 +++++++++++++
 tb/tb_fwd_scoreboard.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Register forwarding scoreboard: tracks busy/valid/data per architectural register,
// accepts forwarded results from several producer channels and answers operand lookups.
module fwd_scoreboard #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 3,
  parameter int NUM_RD         = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          iss_valid,
  input  logic [REG_ADDR_WIDTH-1:0]     iss_rd,
  input  logic                          ret_valid,
  input  logic [REG_ADDR_WIDTH-1:0]     ret_rd,
  input  logic [NUM_SRC-1:0]            src_req,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] src_addr,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_resp,
  output logic [NUM_SRC-1:0]            src_stale,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]             rd_hit,
  output logic [NUM_RD-1:0]             rd_stall,
  output logic [NUM_RD*DATA_WIDTH-1:0]  rd_data,
  output logic [REG_ADDR_WIDTH:0]       busy_cnt
);

  localparam int DEPTH = 1 << REG_ADDR_WIDTH;
  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;

  logic [DEPTH-1:0]          busy_q, busy_d;
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     data_q [DEPTH];
  logic [NUM_SRC-1:0]        resp_q;
  logic [NUM_SRC-1:0]        stale_q, stale_d;
  logic [NUM_SRC-1:0]        fwd_en;
  logic [REG_ADDR_WIDTH:0]   busy_cnt_q, busy_cnt_d;

  addr_t                     s_addr [NUM_SRC];
  logic [DATA_WIDTH-1:0]     s_data [NUM_SRC];
  logic                      iss_ok, ret_ok;

  // Register 0 is hardwired: it can never become busy, so it never forwards or hits.
  assign iss_ok = iss_valid && (iss_rd != '0);
  assign ret_ok = ret_valid && (ret_rd != '0);

  always_comb begin : unpack_src
    for (int i = 0; i < NUM_SRC; i++) begin
      s_addr[i] = src_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      s_data[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin : next_state
    logic collide;
    busy_d  = busy_q;
    valid_d = valid_q;
    fwd_en  = '0;
    stale_d = '0;
    collide = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // A same-cycle issue or retire of the target owns the register; the forward is
      // dropped silently rather than reported stale.
      collide = (iss_ok && (iss_rd == s_addr[i])) || (ret_ok && (ret_rd == s_addr[i]));
      if (src_req[i] && !collide) begin
        if (busy_q[s_addr[i]]) begin
          fwd_en[i]          = 1'b1;
          valid_d[s_addr[i]] = 1'b1;
        end else begin
          stale_d[i] = 1'b1;
        end
      end
    end
    if (ret_ok) begin
      busy_d[ret_rd]  = 1'b0;
      valid_d[ret_rd] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[iss_rd]  = 1'b1;
      valid_d[iss_rd] = 1'b0;
    end
    if (flush) begin
      busy_d  = '0;
      valid_d = '0;
      fwd_en  = '0;
      stale_d = '0;
    end
    busy_cnt_d = (REG_ADDR_WIDTH+1)'($countones(busy_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      valid_q    <= '0;
      busy_cnt_q <= '0;
      resp_q     <= '0;
      stale_q    <= '0;
    end else begin
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      busy_cnt_q <= busy_cnt_d;
      resp_q     <= src_req;
      stale_q    <= stale_d;
    end
  end

  // Ascending loop: later (higher-index) writes to the same register take effect.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fwd_en[i]) data_q[s_addr[i]] <= s_data[i];
    end
  end

  always_comb begin : lookup
    addr_t ra;
    logic  h;
    ra       = '0;
    h        = 1'b0;
    rd_hit   = '0;
    rd_stall = '0;
    rd_data  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra          = rd_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      h           = busy_q[ra] & valid_q[ra];
      rd_hit[p]   = h;
      rd_stall[p] = busy_q[ra] & ~valid_q[ra];
      rd_data[p*DATA_WIDTH +: DATA_WIDTH] = h ? data_q[ra] : '0;
    end
  end

  assign src_resp  = resp_q;
  assign src_stale = stale_q;
  assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed vector table, a reset-during-request sequence,
// then randomized traffic checked against an array-based reference model.
module tb_fwd_scoreboard;

  logic        clk, rst_n, flush, iss_valid, ret_valid;
  logic [4:0]  iss_rd, ret_rd;
  logic [2:0]  src_req, src_resp, src_stale;
  logic [14:0] src_addr;
  logic [95:0] src_data;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_hit, rd_stall;
  logic [63:0] rd_data;
  logic [5:0]  busy_cnt;

  logic [4:0]  saddr [3];
  logic [31:0] sdata [3];
  logic [4:0]  raddr [2];

  assign src_addr = {saddr[2], saddr[1], saddr[0]};
  assign src_data = {sdata[2], sdata[1], sdata[0]};
  assign rd_addr  = {raddr[1], raddr[0]};

  fwd_scoreboard #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_SRC(3), .NUM_RD(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .ret_valid(ret_valid), .ret_rd(ret_rd),
    .src_req(src_req), .src_addr(src_addr), .src_data(src_data),
    .src_resp(src_resp), .src_stale(src_stale),
    .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_stall(rd_stall), .rd_data(rd_data),
    .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain per-register arrays updated with the scoreboard's rules.
  bit          mbusy  [32];
  bit          mvalid [32];
  logic [31:0] mdata  [32];
  logic [2:0]  exp_resp, exp_stale;

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      mbusy[r]  = 0;
      mvalid[r] = 0;
    end
    exp_resp  = '0;
    exp_stale = '0;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(mbusy[r]);
    return n;
  endfunction

  function automatic void model_step();
    bit owned;
    exp_resp  = src_req;
    exp_stale = '0;
    if (flush) begin
      for (int r = 0; r < 32; r++) begin
        mbusy[r]  = 0;
        mvalid[r] = 0;
      end
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (!src_req[i]) continue;
      owned = (saddr[i] != 0) &&
              ((iss_valid && iss_rd == saddr[i]) || (ret_valid && ret_rd == saddr[i]));
      if (owned) continue;
      if (mbusy[saddr[i]]) begin
        mdata[saddr[i]]  = sdata[i];
        mvalid[saddr[i]] = 1;
      end else begin
        exp_stale[i] = 1'b1;
      end
    end
    if (ret_valid && ret_rd != 0) begin
      mbusy[ret_rd]  = 0;
      mvalid[ret_rd] = 0;
    end
    if (iss_valid && iss_rd != 0) begin
      mbusy[iss_rd]  = 1;
      mvalid[iss_rd] = 0;
    end
  endfunction

  typedef struct {
    logic        fl, iv;
    logic [4:0]  ird;
    logic        rv;
    logic [4:0]  rrd;
    logic [2:0]  req;
    logic [4:0]  sa;
    logic [31:0] d0, d1, d2;
    logic [4:0]  ra;
    logic        e_hit, e_stall;
    logic [31:0] e_data;
    logic [2:0]  e_resp, e_stale;
    logic [5:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic iv, input logic [4:0] ird,
                              input logic rv, input logic [4:0] rrd, input logic [2:0] req,
                              input logic [4:0] sa, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [4:0] ra, input logic eh,
                              input logic es, input logic [31:0] ed, input logic [2:0] er,
                              input logic [2:0] est, input logic [5:0] ec);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ird = ird; v.rv = rv; v.rrd = rrd; v.req = req; v.sa = sa;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.ra = ra; v.e_hit = eh; v.e_stall = es; v.e_data = ed;
    v.e_resp = er; v.e_stale = est; v.e_cnt = ec;
    return v;
  endfunction

  task automatic drive_idle();
    flush = 0; iss_valid = 0; iss_rd = 0; ret_valid = 0; ret_rd = 0; src_req = 0;
    for (int i = 0; i < 3; i++) begin saddr[i] = 0; sdata[i] = 0; end
    raddr[0] = 0; raddr[1] = 0;
  endtask

  vec_t tbl [$];

  initial begin
    rst_n = 0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy_cnt", busy_cnt, 0);
    chk("reset_resp", src_resp, 0);
    chk("reset_stale", src_stale, 0);
    chk("reset_hit", rd_hit, 0);
    rst_n = 1;

    //            fl iv ird rv rrd req    sa d0     d1            d2     ra hit st data          resp   stale  cnt
    tbl.push_back(mk(0, 1, 5, 0, 0, 3'b000, 0, 0,     0,            0,     5, 0, 0, 0,            3'b000,3'b000,1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0,     0,            0,     5, 0, 1, 0,            3'b000,3'b000,1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b010, 5, 0,     32'hDEADBEEF, 0,     5, 0, 1, 0,            3'b010,3'b000,1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0,     0,            0,     5, 1, 0, 32'hDEADBEEF, 3'b000,3'b000,1));
    tbl.push_back(mk(0, 1, 7, 0, 0, 3'b000, 0, 0,     0,            0,     7, 0, 0, 0,            3'b000,3'b000,2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b101, 7, 32'h11,0,            32'h22,7, 0, 1, 0,            3'b101,3'b000,2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0,     0,            0,     7, 1, 0, 32'h22,       3'b000,3'b000,2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b001, 9, 32'h99,0,            0,     9, 0, 0, 0,            3'b001,3'b001,2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0,     0,            0,     9, 0, 0, 0,            3'b000,3'b000,2));
    tbl.push_back(mk(0, 1, 3, 0, 0, 3'b000, 0, 0,     0,            0,     3, 0, 0, 0,            3'b000,3'b000,3));
    tbl.push_back(mk(0, 1, 3, 1, 3, 3'b000, 0, 0,     0,            0,     3, 0, 1, 0,            3'b000,3'b000,3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0,     0,            0,     3, 0, 1, 0,            3'b000,3'b000,3));
    tbl.push_back(mk(1, 1,10, 0, 0, 3'b010, 5, 0,     32'h55,       0,     5, 1, 0, 32'hDEADBEEF, 3'b010,3'b000,0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0,     0,            0,     5, 0, 0, 0,            3'b000,3'b000,0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0,     0,            0,     3, 0, 0, 0,            3'b000,3'b000,0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0,     0,            0,    10, 0, 0, 0,            3'b000,3'b000,0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 3'b100, 0, 0,     0,            32'h77,0, 0, 0, 0,            3'b100,3'b100,0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0,     0,            0,     0, 0, 0, 0,            3'b000,3'b000,0));
    tbl.push_back(mk(0, 1,12, 0, 0, 3'b000, 0, 0,     0,            0,    12, 0, 0, 0,            3'b000,3'b000,1));
    tbl.push_back(mk(0, 1,12, 0, 0, 3'b010,12, 0,     32'hAB,       0,    12, 0, 1, 0,            3'b010,3'b000,1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0,     0,            0,    12, 0, 1, 0,            3'b000,3'b000,1));
    tbl.push_back(mk(0, 0, 0, 1,12, 3'b001,12, 32'hCD,0,            0,    12, 0, 1, 0,            3'b001,3'b000,0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0,     0,            0,    12, 0, 0, 0,            3'b000,3'b000,0));

    foreach (tbl[k]) begin
      flush = tbl[k].fl; iss_valid = tbl[k].iv; iss_rd = tbl[k].ird;
      ret_valid = tbl[k].rv; ret_rd = tbl[k].rrd; src_req = tbl[k].req;
      for (int i = 0; i < 3; i++) saddr[i] = tbl[k].sa;
      sdata[0] = tbl[k].d0; sdata[1] = tbl[k].d1; sdata[2] = tbl[k].d2;
      raddr[0] = tbl[k].ra; raddr[1] = 0;
      #1;
      chk($sformatf("vec%0d_hit", k), rd_hit[0], tbl[k].e_hit);
      chk($sformatf("vec%0d_stall", k), rd_stall[0], tbl[k].e_stall);
      chk($sformatf("vec%0d_data", k), rd_data[31:0], tbl[k].e_data);
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("vec%0d_resp", k), src_resp, tbl[k].e_resp);
      chk($sformatf("vec%0d_stale", k), src_stale, tbl[k].e_stale);
      chk($sformatf("vec%0d_cnt", k), busy_cnt, tbl[k].e_cnt);
    end

    // Reset asserted while requests are outstanding.
    drive_idle();
    iss_valid = 1; iss_rd = 4; raddr[0] = 4;
    @(posedge clk); #1;
    chk("rst_seq_cnt", busy_cnt, 1);
    iss_valid = 0; src_req = 3'b111;
    for (int i = 0; i < 3; i++) begin saddr[i] = 4; sdata[i] = 32'hA0 + i; end
    @(posedge clk); #1;
    chk("rst_seq_resp", src_resp, 3'b111);
    chk("rst_seq_hit", rd_hit[0], 1);
    #2 rst_n = 0;
    #1;
    chk("rst_async_resp", src_resp, 0);
    chk("rst_async_stale", src_stale, 0);
    chk("rst_async_cnt", busy_cnt, 0);
    chk("rst_async_hit", rd_hit, 0);
    chk("rst_async_stall", rd_stall, 0);
    @(posedge clk); #1;
    src_req = 0;
    rst_n = 1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_after_resp", src_resp, 0);
    chk("rst_after_cnt", busy_cnt, 0);

    // Randomized traffic on a small register window so collisions are frequent.
    for (int n = 0; n < 400; n++) begin
      flush     = ($urandom_range(0, 31) == 0);
      iss_valid = $urandom_range(0, 1);
      iss_rd    = 5'($urandom_range(0, 7));
      ret_valid = ($urandom_range(0, 2) == 0);
      ret_rd    = 5'($urandom_range(0, 7));
      src_req   = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        saddr[i] = 5'($urandom_range(0, 7));
        sdata[i] = $urandom;
      end
      raddr[0] = 5'($urandom_range(0, 7));
      raddr[1] = 5'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < 2; p++) begin
        logic eh;
        eh = mbusy[raddr[p]] && mvalid[raddr[p]];
        chk($sformatf("rnd%0d_hit%0d", n, p), rd_hit[p], eh);
        chk($sformatf("rnd%0d_stall%0d", n, p), rd_stall[p],
            mbusy[raddr[p]] && !mvalid[raddr[p]]);
        chk($sformatf("rnd%0d_data%0d", n, p), rd_data[p*32 +: 32],
            eh ? mdata[raddr[p]] : 32'h0);
      end
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rnd%0d_resp", n), src_resp, exp_resp);
      chk($sformatf("rnd%0d_stale", n), src_stale, exp_stale);
      chk($sformatf("rnd%0d_cnt", n), busy_cnt, 6'(model_count()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
